// File: rtl/nand_op_sequencer.sv
// nand_op_sequencer
//   Sequences one NAND program-type operation onto the bus-cycle toggle
//   engine: CMD1, 0-5 address bytes, N data bytes, optional CMD2, then an
//   optional tWB delay plus ready/busy wait. Every bus byte is one toggle
//   run of a single WE# pulse, handshaked as LAUNCH (enable until done)
//   then RELEASE (disable until done drops).
//
// Ports
//   clk, reset_n          clock, async active-low reset
//   req                   start, sampled in IDLE only
//   cmd1, cmd2, use_cmd2  command bytes, cmd2 issued after data if use_cmd2
//   addr, addr_cycles     address bytes (LSB byte first), count 0-5 (6,7 -> 5)
//   data_cycles           data byte count, 0 = none
//   wait_rb               wait tWB then for rb_n high after the last byte
//   wr_data/wr_valid/wr_pop  show-ahead write data source
//   rb_n                  flash ready/busy (async, low = busy)
//   tg_enable/tg_cnt/tg_setup/tg_hold/tg_done  toggle engine interface
//   io_data, io_oe        flash I/O byte and output enable
//   busy, op_done, op_err status; op_err = ready/busy timeout
module nand_op_sequencer #(
    parameter int TWB_CYC    = 20,
    parameter int RB_TIMEOUT = 1048576,
    parameter int DATA_W     = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic [7:0]        cmd1,
    input  logic [7:0]        cmd2,
    input  logic              use_cmd2,
    input  logic [39:0]       addr,
    input  logic [2:0]        addr_cycles,
    input  logic [DATA_W-1:0] data_cycles,
    input  logic              wait_rb,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    output logic              wr_pop,
    input  logic              rb_n,
    output logic              tg_enable,
    output logic [11:0]       tg_cnt,
    output logic [4:0]        tg_setup,
    output logic [4:0]        tg_hold,
    input  logic              tg_done,
    output logic [7:0]        io_data,
    output logic              io_oe,
    output logic              busy,
    output logic              op_done,
    output logic              op_err
);

    // Control vectors {CE#,CLE,ALE,WE#,RE#}
    localparam logic [4:0] VEC_IDLE = 5'b10011;
    localparam logic [4:0] CMD_SU   = 5'b01001;
    localparam logic [4:0] CMD_HD   = 5'b01011;
    localparam logic [4:0] ADR_SU   = 5'b00101;
    localparam logic [4:0] ADR_HD   = 5'b00111;
    localparam logic [4:0] DAT_SU   = 5'b00001;
    localparam logic [4:0] DAT_HD   = 5'b00011;

    localparam logic [20:0] TWB_LAST = 21'(TWB_CYC - 1);
    localparam logic [20:0] RB_LAST  = 21'(RB_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD1, S_ADDR, S_DATA, S_CMD2, S_TWB, S_RBWAIT, S_FIN
    } state_t;

    // PRE gates every launch on tg_done low (and wr_valid for data bytes)
    typedef enum logic [1:0] {P_PRE, P_LAUNCH, P_RELEASE} phase_t;

    state_t             state, state_n;
    phase_t             phase, phase_n;
    logic [2:0]         aidx, aidx_n;
    logic [DATA_W-1:0]  didx, didx_n;
    logic [20:0]        tmr, tmr_n;

    logic [7:0]         cmd1_q, cmd2_q, byte_q;
    logic [39:0]        addr_q;
    logic [2:0]         acyc_q;
    logic [DATA_W-1:0]  dcyc_q;
    logic               use_cmd2_q, wait_rb_q;
    logic               pop_q, err_q;
    logic [1:0]         rb_sync;

    logic               latch, launch, err_set, last_byte, run;
    logic [7:0]         addr_byte, next_byte;
    state_t             after_cmd1, after_addr, after_data, after_cmd2, after_run;

    // Phase-skip chain: each phase falls through to the next enabled one
    always_comb begin
        after_cmd2 = wait_rb_q ? S_TWB : S_FIN;
        after_data = use_cmd2_q ? S_CMD2 : after_cmd2;
        after_addr = (dcyc_q != '0) ? S_DATA : after_data;
        after_cmd1 = (acyc_q != 3'd0) ? S_ADDR : after_addr;
    end

    always_comb begin
        case (aidx)
            3'd0:    addr_byte = addr_q[7:0];
            3'd1:    addr_byte = addr_q[15:8];
            3'd2:    addr_byte = addr_q[23:16];
            3'd3:    addr_byte = addr_q[31:24];
            default: addr_byte = addr_q[39:32];
        endcase
    end

    always_comb begin
        last_byte = 1'b1;
        after_run = after_cmd2;
        next_byte = 8'h00;
        case (state)
            S_CMD1: begin after_run = after_cmd1; next_byte = cmd1_q; end
            S_ADDR: begin
                after_run = after_addr;
                next_byte = addr_byte;
                last_byte = (aidx == acyc_q - 3'd1);
            end
            S_DATA: begin
                after_run = after_data;
                next_byte = wr_data;
                // compare against count-1 so a full-scale count never wraps
                last_byte = (didx == dcyc_q - DATA_W'(1));
            end
            S_CMD2: next_byte = cmd2_q;
            default: ;
        endcase
    end

    assign run = (state == S_CMD1) || (state == S_ADDR) ||
                 (state == S_DATA) || (state == S_CMD2);

    always_comb begin
        state_n = state;
        phase_n = phase;
        aidx_n  = aidx;
        didx_n  = didx;
        tmr_n   = tmr;
        latch   = 1'b0;
        launch  = 1'b0;
        err_set = 1'b0;
        case (state)
            S_IDLE: if (req) begin
                latch   = 1'b1;
                state_n = S_CMD1;
                phase_n = P_PRE;
                aidx_n  = '0;
                didx_n  = '0;
                tmr_n   = '0;
            end
            S_CMD1, S_ADDR, S_DATA, S_CMD2: begin
                case (phase)
                    P_PRE: if (!tg_done && (state != S_DATA || wr_valid)) begin
                        launch  = 1'b1;
                        phase_n = P_LAUNCH;
                    end
                    P_LAUNCH: if (tg_done) phase_n = P_RELEASE;
                    P_RELEASE: if (!tg_done) begin
                        phase_n = P_PRE;
                        if (!last_byte && state == S_ADDR)      aidx_n = aidx + 3'd1;
                        else if (!last_byte && state == S_DATA) didx_n = didx + DATA_W'(1);
                        else begin
                            state_n = after_run;
                            tmr_n   = '0;
                        end
                    end
                    default: phase_n = P_PRE;
                endcase
            end
            S_TWB: begin
                if (tmr == TWB_LAST) begin
                    tmr_n   = '0;
                    state_n = S_RBWAIT;
                end else begin
                    tmr_n = tmr + 21'd1;
                end
            end
            S_RBWAIT: begin
                if (rb_sync[1]) begin
                    state_n = S_FIN;
                end else if (tmr == RB_LAST) begin
                    err_set = 1'b1;
                    state_n = S_FIN;
                end else begin
                    tmr_n = tmr + 21'd1;
                end
            end
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            phase      <= P_PRE;
            aidx       <= '0;
            didx       <= '0;
            tmr        <= '0;
            cmd1_q     <= '0;
            cmd2_q     <= '0;
            addr_q     <= '0;
            acyc_q     <= '0;
            dcyc_q     <= '0;
            use_cmd2_q <= 1'b0;
            wait_rb_q  <= 1'b0;
            byte_q     <= '0;
            pop_q      <= 1'b0;
            err_q      <= 1'b0;
            rb_sync    <= 2'b11;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            aidx    <= aidx_n;
            didx    <= didx_n;
            tmr     <= tmr_n;
            rb_sync <= {rb_sync[0], rb_n};
            if (latch) begin
                cmd1_q     <= cmd1;
                cmd2_q     <= cmd2;
                addr_q     <= addr;
                acyc_q     <= (addr_cycles > 3'd5) ? 3'd5 : addr_cycles;
                dcyc_q     <= data_cycles;
                use_cmd2_q <= use_cmd2;
                wait_rb_q  <= wait_rb;
            end
            // byte captured on launch so it is stable for the whole run
            if (launch) byte_q <= next_byte;
            pop_q <= launch && (state == S_DATA);
            if (latch)        err_q <= 1'b0;
            else if (err_set) err_q <= 1'b1;
        end
    end

    always_comb begin
        tg_setup = VEC_IDLE;
        tg_hold  = VEC_IDLE;
        case (state)
            S_CMD1, S_CMD2: begin tg_setup = CMD_SU; tg_hold = CMD_HD; end
            S_ADDR:         begin tg_setup = ADR_SU; tg_hold = ADR_HD; end
            S_DATA:         begin tg_setup = DAT_SU; tg_hold = DAT_HD; end
            default: ;
        endcase
    end

    assign tg_enable = run && (phase == P_LAUNCH);
    assign tg_cnt    = 12'd1;
    assign io_oe     = run;
    assign io_data   = run ? byte_q : 8'h00;
    assign wr_pop    = pop_q;
    assign busy      = (state != S_IDLE);
    assign op_done   = (state == S_FIN);
    assign op_err    = err_q;

endmodule

// File: tb/tb_nand_op_sequencer.sv
module tb_nand_op_sequencer;
    localparam int TWB = 20;
    localparam int RBT = 100;

    logic        clk = 1'b0, reset_n = 1'b0, req = 1'b0;
    logic [7:0]  cmd1 = 8'h00, cmd2 = 8'h00;
    logic        use_cmd2 = 1'b0, wait_rb = 1'b0;
    logic [39:0] addr = '0;
    logic [2:0]  addr_cycles = '0;
    logic [11:0] data_cycles = '0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_valid = 1'b0, rb_n = 1'b1, tg_done = 1'b0;
    logic        wr_pop, tg_enable, io_oe, busy, op_done, op_err;
    logic [11:0] tg_cnt;
    logic [4:0]  tg_setup, tg_hold;
    logic [7:0]  io_data;

    nand_op_sequencer #(.TWB_CYC(TWB), .RB_TIMEOUT(RBT), .DATA_W(12)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .cmd1(cmd1), .cmd2(cmd2),
        .use_cmd2(use_cmd2), .addr(addr), .addr_cycles(addr_cycles),
        .data_cycles(data_cycles), .wait_rb(wait_rb), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_pop(wr_pop), .rb_n(rb_n), .tg_enable(tg_enable),
        .tg_cnt(tg_cnt), .tg_setup(tg_setup), .tg_hold(tg_hold), .tg_done(tg_done),
        .io_data(io_data), .io_oe(io_oe), .busy(busy), .op_done(op_done), .op_err(op_err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [4:0] s; logic [4:0] h; logic [7:0] d; } run_t;

    int checks = 0, errors = 0, cyc = 0;
    // engine / monitor state (owned by the negedge model)
    int pops = 0, dones = 0, bad_en = 0, unstable = 0, stall_launch = 0;
    int rel_cyc = 0, done_cyc = 0, eng_dly = 0, stall_cnt = 0, rb_cnt = 0;
    int rptr = 0, gcnt = 0;
    logic prev_en = 1'b0;
    logic [7:0] launch_d = 8'h00;
    logic [4:0] gs [0:8191];
    logic [4:0] gh [0:8191];
    logic [7:0] gd [0:8191];
    // stimulus state (owned by the initial block)
    logic [7:0] wmem [0:8191];
    int wptr = 0, stall_at = -1, rb_arm = 0;
    logic rb_hold = 1'b0;
    run_t exp_q[$];
    logic [7:0] edq[$];
    int d0, g0, p0, nd, sl0, cnt;

    always @(posedge clk) cyc <= cyc + 1;

    // Toggle engine model + monitors: one WE# pulse per run with random latency
    always @(negedge clk) begin
        if (!reset_n) begin
            tg_done = 1'b0; eng_dly = 0; prev_en = 1'b0; stall_cnt = 0;
        end else begin
            if (stall_cnt > 0) stall_cnt--;
            if (rb_cnt > 0) rb_cnt--;
            if (tg_enable && !prev_en) begin
                launch_d = io_data;
                if (tg_done) bad_en++;
                if (stall_cnt > 0) stall_launch++;
                eng_dly = $urandom_range(0, 2);
            end
            if (tg_enable && !tg_done) begin
                if (eng_dly > 0) eng_dly--;
                else begin
                    tg_done = 1'b1;
                    gs[gcnt] = tg_setup; gh[gcnt] = tg_hold; gd[gcnt] = io_data;
                    gcnt++;
                    if (io_data !== launch_d) unstable++;
                    eng_dly = $urandom_range(0, 2);
                end
            end else if (!tg_enable && tg_done) begin
                if (eng_dly > 0) eng_dly--;
                else begin
                    tg_done = 1'b0;
                    rel_cyc = cyc;
                    if (rb_arm > 0) rb_cnt = rb_arm;
                end
            end
            prev_en = tg_enable;
            if (wr_pop) begin
                pops++;
                rptr++;
                if (pops == stall_at) stall_cnt = 10;
            end
            if (op_done) begin dones++; done_cyc = cyc; end
        end
        wr_data  = (rptr < wptr) ? wmem[rptr] : 8'h00;
        wr_valid = (rptr < wptr) && (stall_cnt == 0);
        rb_n     = !(rb_hold || rb_cnt > 0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_data(input logic [7:0] b);
        wmem[wptr] = b;
        wptr++;
        edq.push_back(b);
    endtask

    // Expected run list built directly from the operation description
    task automatic start_op(input logic [7:0] c1, input logic [2:0] ac, input logic [39:0] a,
                            input logic [11:0] dc, input logic u2, input logic [7:0] c2,
                            input logic wrb);
        int na;
        na = (ac > 5) ? 5 : int'(ac);
        exp_q.delete();
        exp_q.push_back({5'b01001, 5'b01011, c1});
        for (int i = 0; i < na; i++) exp_q.push_back({5'b00101, 5'b00111, a[i*8 +: 8]});
        foreach (edq[i]) exp_q.push_back({5'b00001, 5'b00011, edq[i]});
        edq.delete();
        if (u2) exp_q.push_back({5'b01001, 5'b01011, c2});
        nd = int'(dc);
        d0 = dones; g0 = gcnt; p0 = pops;
        cmd1 = c1; addr_cycles = ac; addr = a; data_cycles = dc;
        use_cmd2 = u2; cmd2 = c2; wait_rb = wrb;
        req = 1'b1;
        tick(1);
        req = 1'b0;
        chk("busy_after_req", busy, 1);
        chk("err_clr_on_req", op_err, 0);
    endtask

    task automatic finish_op(input string tag, input int lim, input logic experr);
        for (int i = 0; i < lim && dones == d0; i++) tick(1);
        tick(2);
        chk({tag, ".done_once"}, dones - d0, 1);
        chk({tag, ".err"}, op_err, experr);
        chk({tag, ".busy_end"}, busy, 0);
        chk({tag, ".nruns"}, gcnt - g0, exp_q.size());
        for (int i = 0; i < exp_q.size() && g0 + i < gcnt; i++)
            chk($sformatf("%s.run%0d", tag, i), {gs[g0+i], gh[g0+i], gd[g0+i]}, exp_q[i]);
        chk({tag, ".pops"}, pops - p0, nd);
        chk({tag, ".stable"}, unstable, 0);
        chk({tag, ".no_en_while_done"}, bad_en, 0);
    endtask

    initial begin
        // reset state
        tick(3);
        chk("rst.tg_enable", tg_enable, 0);
        chk("rst.busy", busy, 0);
        chk("rst.tg_setup", tg_setup, 5'b10011);
        chk("rst.tg_hold", tg_hold, 5'b10011);
        chk("rst.io", {io_oe, io_data}, 0);
        chk("rst.flags", {wr_pop, op_done, op_err}, 0);
        reset_n = 1'b1;
        tick(2);
        chk("tg_cnt", tg_cnt, 1);

        // full program sequence
        push_data(8'hAA); push_data(8'h55);
        start_op(8'h80, 3'd5, 40'h0403020100, 12'd2, 1'b1, 8'h10, 1'b0);
        finish_op("prog", 2000, 1'b0);

        // cmd only with tWB + busy wait
        rb_arm = TWB + 50;
        start_op(8'hFF, 3'd0, 40'h0, 12'd0, 1'b0, 8'h00, 1'b1);
        finish_op("rbwait", 2000, 1'b0);
        rb_arm = 0;
        chk("rbwait.min_lat", (done_cyc - rel_cyc) >= TWB + 50, 1);
        chk("rbwait.max_lat", (done_cyc - rel_cyc) <= TWB + 60, 1);

        // rb_n stuck low -> timeout
        rb_hold = 1'b1;
        start_op(8'hFF, 3'd0, 40'h0, 12'd0, 1'b0, 8'h00, 1'b1);
        finish_op("timeout", 2000, 1'b1);
        chk("timeout.min_lat", (done_cyc - rel_cyc) >= TWB + RBT, 1);
        chk("timeout.max_lat", (done_cyc - rel_cyc) <= TWB + RBT + 10, 1);
        rb_hold = 1'b0;
        tick(5);
        chk("timeout.err_held", op_err, 1);

        // data stall before byte 2
        for (int i = 0; i < 3; i++) push_data(8'($urandom));
        stall_at = pops + 1;
        sl0 = stall_launch;
        start_op(8'h85, 3'd2, {8'h0, 32'($urandom)}, 12'd3, 1'b0, 8'h00, 1'b0);
        finish_op("stall", 2000, 1'b0);
        chk("stall.no_launch", stall_launch - sl0, 0);
        stall_at = -1;

        // reset during address phase
        start_op(8'h80, 3'd5, 40'h1122334455, 12'd0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 200 && tg_setup !== 5'b00101; i++) tick(1);
        chk("mid_rst.reach_addr", tg_setup, 5'b00101);
        tick(1);
        reset_n = 1'b0;
        tick(1);
        chk("mid_rst.tg_enable", tg_enable, 0);
        chk("mid_rst.busy", busy, 0);
        chk("mid_rst.tg_setup", tg_setup, 5'b10011);
        chk("mid_rst.io_oe", io_oe, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        push_data(8'h3C);
        start_op(8'h80, 3'd3, 40'h0000ABCDEF, 12'd1, 1'b1, 8'h10, 1'b0);
        finish_op("after_rst", 2000, 1'b0);

        // addr_cycles=7 clamps to 5; second req while busy ignored
        push_data(8'h99);
        start_op(8'h80, 3'd7, 40'hA5A4A3A2A1, 12'd1, 1'b1, 8'h15, 1'b0);
        tick(4);
        cmd1 = 8'h60; addr_cycles = 3'd1; data_cycles = 12'd0; use_cmd2 = 1'b0;
        req = 1'b1; tick(1); req = 1'b0;
        finish_op("clamp", 2000, 1'b0);
        cnt = 0;
        for (int i = g0; i < gcnt; i++) if (gs[i] == 5'b00101) cnt++;
        chk("clamp.addr_runs", cnt, 5);

        // randomized operations
        for (int k = 0; k < 6; k++) begin
            logic [2:0]  ac;
            logic [11:0] dc;
            ac = 3'($urandom_range(0, 7));
            dc = 12'($urandom_range(0, 6));
            for (int i = 0; i < int'(dc); i++) push_data(8'($urandom));
            start_op(8'($urandom), ac, {8'($urandom), 32'($urandom)}, dc,
                     1'($urandom), 8'($urandom), 1'($urandom));
            finish_op($sformatf("rnd%0d", k), 3000, 1'b0);
        end

        // full-scale data count
        for (int i = 0; i < 4095; i++) push_data(8'($urandom));
        start_op(8'h80, 3'd0, 40'h0, 12'd4095, 1'b1, 8'h10, 1'b0);
        finish_op("max_data", 60000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nand_op_sequencer.md
Name: nand_op_sequencer

Overview:
- Controller that sequences one NAND flash program-type operation onto the bus-cycle toggle engine.
- Sequence: command byte, 0-5 address bytes, N data bytes, optional second command byte, optional ready/busy wait.
- Each bus byte is one toggle-engine run of exactly one WE# pulse.
- Per run, the block drives the byte on io_data and selects the setup/hold control vectors.
- Sits between the host command interface and the toggle engine/pad logic.

Parameters:
- TWB_CYC, 20: clk cycles waited after the last WE# run before sampling rb_n (tWB).
- RB_TIMEOUT, 1048576: max clk cycles rb_n may stay low before timeout error (width 21 bits).
- DATA_W, 12: width of data byte count.

Ports:
- clk  in  1  system clock (200 MHz domain)
- reset_n  in  1  asynchronous active-low reset
- req  in  1  start operation; sampled only in IDLE
- cmd1  in  8  first command byte
- cmd2  in  8  second command byte
- use_cmd2  in  1  1 = issue cmd2 after data
- addr  in  40  address bytes, byte 0 = addr[7:0], sent first
- addr_cycles  in  3  address bytes to send, 0-5; values 6-7 treated as 5
- data_cycles  in  DATA_W  data bytes to send; 0 = none
- wait_rb  in  1  1 = wait for ready after last byte
- wr_data  in  8  show-ahead write data byte
- wr_valid  in  1  wr_data valid
- wr_pop  out  1  1-cycle pop of wr_data, asserted when a data run launches
- rb_n  in  1  flash ready/busy, async, low = busy
- tg_enable  out  1  toggle engine enable
- tg_cnt  out  12  pulses per run; constant 12'd1
- tg_setup  out  5  setup vector {CE#,CLE,ALE,WE#,RE#}
- tg_hold  out  5  hold vector
- tg_done  in  1  toggle engine done
- io_data  out  8  byte driven to flash I/O
- io_oe  out  1  I/O output enable
- busy  out  1  operation in progress
- op_done  out  1  1-cycle completion pulse
- op_err  out  1  timeout flag, valid with op_done, held until next req accepted

Behaviour:
- Reset values (async, reset_n low):
  - tg_enable, wr_pop, io_oe, busy, op_done, op_err, io_data = 0.
  - tg_setup = tg_hold = 5'b10011 (CE# high, WE#/RE# high).
  - State = IDLE; rb_n synchronizer = 2'b11.
- Input latching: req in IDLE latches all operation inputs; busy = 1 from the next cycle until op_done.
- Run vectors, in setup/hold form:
  - CMD: 5'b01001 / 5'b01011
  - ADDR: 5'b00101 / 5'b00111
  - DATA: 5'b00001 / 5'b00011
- Run protocol, LAUNCH then RELEASE:
  - LAUNCH: drive io_data, io_oe = 1, vectors, tg_enable = 1; hold until tg_done = 1.
  - RELEASE: tg_enable = 0; hold until tg_done = 0.
  - Then advance.
  - io_data and vectors stable from LAUNCH entry through RELEASE exit.
- States:
  - IDLE
  - CMD1 (launch/release)
  - ADDR (launch/release, address byte counter 0..addr_cycles-1)
  - DATA (launch/release, 12-bit byte counter)
  - CMD2 (launch/release)
  - TWB
  - RBWAIT
  - FIN
- Transitions:
  - IDLE -> CMD1 on req.
  - CMD1 -> ADDR if addr_cycles > 0, else DATA/CMD2/TWB/FIN, skipping each zero or disabled phase in that order.
  - ADDR, DATA and CMD2 follow the same skip rule after their last byte.
  - TWB counts TWB_CYC cycles -> RBWAIT.
  - RBWAIT exits to FIN when synced rb_n = 1, or when the timeout counter reaches RB_TIMEOUT (sets op_err).
  - FIN: op_done = 1 for one cycle -> IDLE.
  - wait_rb = 0 skips TWB and RBWAIT.
- DATA stall: LAUNCH entry waits in a pre-launch substate while wr_valid = 0 (tg_enable stays 0). wr_pop pulses in the first LAUNCH cycle of each data byte.
- io_oe = 0 in IDLE, TWB, RBWAIT and FIN; CE# vectors return to the reset value there.
- The block never asserts tg_enable while tg_done = 1 from a previous run.
- req while busy is ignored.
- Reset mid-operation: all outputs return to reset values immediately. The toggle engine is reset by the same reset_n, so no handshake cleanup is needed.
- Counter wrap: the data counter compares equal to data_cycles - 1 and never wraps. data_cycles = 4095 sends 4095 bytes.

Test Plan:
- cmd1=80h, addr_cycles=5, addr=40'h0403020100, data_cycles=2 (wr_data AA,55), use_cmd2=1 cmd2=10h, wait_rb=0 -> io_data sequence 80,00,01,02,03,04,AA,55,10; 9 tg_enable runs; exactly 2 wr_pop; op_done once; op_err=0.
- cmd1=FFh, addr_cycles=0, data_cycles=0, use_cmd2=0, wait_rb=1, rb_n low 50 cycles after run -> one CMD run with tg_setup=01001; op_done no earlier than TWB_CYC+50 cycles after the release; op_err=0.
- Same as the previous case with rb_n held low and RB_TIMEOUT overridden to 100 -> op_done with op_err=1; op_err stays 1 until the next req.
- data_cycles=3, wr_valid dropped for 10 cycles before byte 2 -> tg_enable low during the stall; bytes sent in order; wr_pop count = 3.
- reset_n asserted during the ADDR phase -> next cycle tg_enable=0, busy=0, tg_setup=10011; a new req after release completes normally.
- req pulsed while busy, and addr_cycles=7 -> second req ignored; exactly 5 address runs.
